// File: rtl/encrypter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : encrypter_scheduler
// Brief    : Keys NUM_ENC Encrypter lanes, round-robins words through them and
//            returns results in acceptance order on one valid/ready stream.
// Revision : 1.0
// ============================================================================
module encrypter_scheduler #(
    parameter int WIDTH     = 32,
    parameter int ROT_WIDTH = 5,
    parameter int NUM_ENC   = 4,
    parameter int LANE_W    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             key_in,
    input  logic                         key_load,
    output logic                         key_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [ROT_WIDTH-1:0]         in_rot,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         enc_reset_o,
    output logic                         enc_prog_o,
    output logic [NUM_ENC*WIDTH-1:0]     enc_data_o,
    output logic [NUM_ENC*ROT_WIDTH-1:0] enc_rot_o,
    output logic [NUM_ENC-1:0]           enc_dvalid_o,
    input  logic [NUM_ENC-1:0]           enc_ready_i,
    input  logic [NUM_ENC*WIDTH-1:0]     enc_result_i,
    input  logic [NUM_ENC-1:0]           enc_rvalid_i,
    output logic [NUM_ENC-1:0]           enc_capture_o,
    output logic [LANE_W:0]              in_flight
);

    typedef enum logic [2:0] {
        S_UNKEYED = 3'd0,
        S_CLR     = 3'd1,
        S_PROG    = 3'd2,
        S_KEYHOLD = 3'd3,
        S_WAITRDY = 3'd4,
        S_RUN     = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    localparam logic [LANE_W:0] c_full = (LANE_W+1)'(NUM_ENC);

    state_t                                 state_q;
    logic [WIDTH-1:0]                       key_q;
    logic                                   key_ready_q;
    logic                                   enc_reset_q;
    logic                                   enc_prog_q;
    logic [LANE_W-1:0]                      dptr_q;
    logic [LANE_W-1:0]                      cptr_q;
    logic [LANE_W:0]                        in_flight_q;
    logic [NUM_ENC-1:0][WIDTH-1:0]          lane_data_q;
    logic [NUM_ENC-1:0][ROT_WIDTH-1:0]      lane_rot_q;
    logic [NUM_ENC-1:0]                     dvalid_q;
    logic [NUM_ENC-1:0]                     busy_q;
    logic [NUM_ENC-1:0]                     capt_q;
    logic [NUM_ENC-1:0]                     capture_q;
    logic [WIDTH-1:0]                       out_data_q;
    logic                                   out_valid_q;

    logic                                   w_key_take;
    logic                                   w_accept;
    logic                                   w_collect;
    logic [NUM_ENC-1:0]                     w_done;
    logic [LANE_W:0]                        w_n_done;
    logic [WIDTH-1:0]                       w_result;

    assign w_key_take = key_load & key_ready_q;

    // Only lane dptr is ever offered a word, which keeps results in order.
    assign in_ready = (state_q == S_RUN) & ~w_key_take
                    & ~dvalid_q[dptr_q] & ~busy_q[dptr_q]
                    & enc_ready_i[dptr_q] & (in_flight_q < c_full);
    assign w_accept = in_valid & in_ready;

    assign w_collect = ((state_q == S_RUN) || (state_q == S_DRAIN))
                     & enc_rvalid_i[cptr_q] & busy_q[cptr_q] & ~capt_q[cptr_q]
                     & (~out_valid_q | out_ready);

    // A captured lane is released once it drops its result valid.
    assign w_done = capt_q & ~enc_rvalid_i;

    always_comb begin
        w_n_done = '0;
        w_result = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            w_n_done = w_n_done + (LANE_W+1)'(w_done[i]);
            if (cptr_q == LANE_W'(i)) begin
                w_result = enc_result_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_UNKEYED;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            enc_reset_q <= 1'b1;
            enc_prog_q  <= 1'b0;
            dptr_q      <= '0;
            cptr_q      <= '0;
            in_flight_q <= '0;
            lane_data_q <= '0;
            lane_rot_q  <= '0;
            dvalid_q    <= '0;
            busy_q      <= '0;
            capt_q      <= '0;
            capture_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            capture_q <= '0;

            case (state_q)
                S_UNKEYED: begin
                    if (w_key_take) begin
                        key_q       <= key_in;
                        key_ready_q <= 1'b0;
                        state_q     <= S_CLR;
                    end else begin
                        key_ready_q <= 1'b1;
                    end
                end
                S_CLR: begin
                    enc_reset_q <= 1'b0;
                    enc_prog_q  <= 1'b1;
                    lane_data_q <= {NUM_ENC{key_q}};
                    dptr_q      <= '0;
                    cptr_q      <= '0;
                    dvalid_q    <= '0;
                    busy_q      <= '0;
                    capt_q      <= '0;
                    state_q     <= S_PROG;
                end
                S_PROG: begin
                    enc_prog_q <= 1'b0;
                    state_q    <= S_KEYHOLD;
                end
                S_KEYHOLD: begin
                    state_q <= S_WAITRDY;
                end
                S_WAITRDY: begin
                    if (&enc_ready_i) begin
                        key_ready_q <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_key_take) begin
                        key_q       <= key_in;
                        key_ready_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((in_flight_q == '0) && (enc_rvalid_i == '0)) begin
                        enc_reset_q <= 1'b1;
                        state_q     <= S_CLR;
                    end
                end
                default: begin
                    enc_reset_q <= 1'b1;
                    enc_prog_q  <= 1'b0;
                    key_ready_q <= 1'b0;
                    state_q     <= S_UNKEYED;
                end
            endcase

            // Word valid is held until the lane shows it has taken the word.
            for (int i = 0; i < NUM_ENC; i++) begin
                if (dvalid_q[i] && !enc_ready_i[i]) begin
                    dvalid_q[i] <= 1'b0;
                end
                if (w_done[i]) begin
                    busy_q[i] <= 1'b0;
                    capt_q[i] <= 1'b0;
                end
            end

            if (w_accept) begin
                lane_data_q[dptr_q] <= in_data;
                lane_rot_q[dptr_q]  <= in_rot;
                dvalid_q[dptr_q]    <= 1'b1;
                busy_q[dptr_q]      <= 1'b1;
                dptr_q              <= dptr_q + 1'b1;
            end

            if (w_collect) begin
                out_data_q        <= w_result;
                out_valid_q       <= 1'b1;
                capture_q[cptr_q] <= 1'b1;
                capt_q[cptr_q]    <= 1'b1;
                cptr_q            <= cptr_q + 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            in_flight_q <= in_flight_q + (LANE_W+1)'(w_accept) - w_n_done;
        end
    end

    assign key_ready     = key_ready_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign enc_reset_o   = enc_reset_q;
    assign enc_prog_o    = enc_prog_q;
    assign enc_data_o    = lane_data_q;
    assign enc_rot_o     = lane_rot_q;
    assign enc_dvalid_o  = dvalid_q;
    assign enc_capture_o = capture_q;
    assign in_flight     = in_flight_q;

endmodule
`default_nettype wire

// File: tb/tb_encrypter_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_encrypter_scheduler
// Brief    : Directed/random bench for encrypter_scheduler with behavioural
//            Encrypter lanes and an in-order expected-result queue.
// Revision : 1.0
// ============================================================================
module tb_encrypter_scheduler;

    localparam int W  = 32;
    localparam int RW = 5;
    localparam int N  = 4;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [W-1:0]      key_in;
    logic              key_load;
    logic              key_ready;
    logic [W-1:0]      in_data;
    logic [RW-1:0]     in_rot;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              enc_reset_o;
    logic              enc_prog_o;
    logic [N*W-1:0]    enc_data_o;
    logic [N*RW-1:0]   enc_rot_o;
    logic [N-1:0]      enc_dvalid_o;
    logic [N-1:0]      enc_ready_i;
    logic [N*W-1:0]    enc_result_i;
    logic [N-1:0]      enc_rvalid_i;
    logic [N-1:0]      enc_capture_o;
    logic [LW:0]       in_flight;

    encrypter_scheduler #(
        .WIDTH(W), .ROT_WIDTH(RW), .NUM_ENC(N), .LANE_W(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
        .in_data(in_data), .in_rot(in_rot), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .enc_reset_o(enc_reset_o), .enc_prog_o(enc_prog_o),
        .enc_data_o(enc_data_o), .enc_rot_o(enc_rot_o), .enc_dvalid_o(enc_dvalid_o),
        .enc_ready_i(enc_ready_i), .enc_result_i(enc_result_i),
        .enc_rvalid_i(enc_rvalid_i), .enc_capture_o(enc_capture_o),
        .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] k, input logic [RW-1:0] r);
        logic [2*W-1:0] t;
        t = {k, k} << r;
        return t[2*W-1:W];
    endfunction

    // Behavioural Encrypter lanes with a random 1..4 cycle latency.
    logic [N-1:0] l_ready = '0;
    logic [N-1:0] l_rvalid = '0;
    logic [N-1:0] l_busy = '0;
    logic [W-1:0] l_key [N];
    logic [W-1:0] l_d   [N];
    logic [W-1:0] l_res [N];
    logic [RW-1:0] l_r  [N];
    logic [1:0]   l_cnt [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (enc_reset_o) begin
                l_ready[i]  <= 1'b0;
                l_rvalid[i] <= 1'b0;
                l_busy[i]   <= 1'b0;
            end else if (enc_prog_o) begin
                l_key[i]   <= enc_data_o[i*W +: W];
                l_ready[i] <= 1'b1;
            end else if (l_rvalid[i]) begin
                if (enc_capture_o[i]) begin
                    l_rvalid[i] <= 1'b0;
                    l_ready[i]  <= 1'b1;
                end
            end else if (l_busy[i]) begin
                if (l_cnt[i] == 2'd0) begin
                    l_busy[i]   <= 1'b0;
                    l_rvalid[i] <= 1'b1;
                    l_res[i]    <= l_d[i] ^ rotl(l_key[i], l_r[i]);
                end else begin
                    l_cnt[i] <= l_cnt[i] - 2'd1;
                end
            end else if (l_ready[i] && enc_dvalid_o[i]) begin
                l_d[i]     <= enc_data_o[i*W +: W];
                l_r[i]     <= enc_rot_o[i*RW +: RW];
                l_ready[i] <= 1'b0;
                l_busy[i]  <= 1'b1;
                l_cnt[i]   <= 2'($urandom_range(0, 3));
            end
        end
    end

    assign enc_ready_i  = l_ready;
    assign enc_rvalid_i = l_rvalid;
    always_comb begin
        enc_result_i = '0;
        for (int i = 0; i < N; i++) enc_result_i[i*W +: W] = l_res[i];
    end

    // Reference model: every accepted word queues data ^ rotl(key, rot).
    logic [W-1:0] exp_q [$];
    logic [W-1:0] model_key;
    logic [W-1:0] last_out;
    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    int ready_pct = 0;
    logic got_acc;
    logic got_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [W-1:0] e;
        got_acc = 1'b0;
        got_out = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data ^ rotl(model_key, in_rot));
            got_acc = 1'b1;
            n_acc++;
        end
        if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'bx}};
            last_out = out_data;
            got_out = 1'b1;
            n_out++;
            check("out_data", out_data, e);
        end
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [RW-1:0] r);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_rot   = r;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!got_acc && t < 200);
        in_valid = 1'b0;
        check("accept", got_acc, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_flight != 0 || out_valid) && t < 1000) begin
            cycle();
            t++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_in_flight", in_flight, 0);
    endtask

    initial begin
        int t;
        int viol;
        int acc0;
        int out0;
        logic [W-1:0] base;

        in_valid = 1'b0; in_data = '0; in_rot = '0; out_ready = 1'b0;
        key_load = 1'b0; key_in = '0; model_key = '0; last_out = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enc_reset", enc_reset_o, 1'b1);
        check("rst_outputs", {in_ready, out_valid, key_ready, enc_prog_o,
                              enc_dvalid_o, enc_capture_o, in_flight}, 0);
        check("rst_lane_data", enc_data_o, 0);
        check("rst_lane_rot", enc_rot_o, 0);
        reset = 1'b0;
        cycle();
        check("unkeyed_key_ready", key_ready, 1'b1);

        // Key program sequence
        model_key = 32'hA5A50F0F;
        key_in = model_key;
        key_load = 1'b1;
        cycle();
        key_load = 1'b0;
        check("clr_state", {enc_reset_o, enc_prog_o, key_ready}, 3'b100);
        cycle();
        check("prog_state", {enc_reset_o, enc_prog_o}, 2'b01);
        check("prog_bus", enc_data_o, {N{model_key}});
        cycle();
        check("keyhold_state", {enc_reset_o, enc_prog_o, key_ready}, 3'b000);
        check("keyhold_bus", enc_data_o, {N{model_key}});
        cycle();
        check("waitrdy_key_ready", key_ready, 1'b0);
        cycle();
        check("run_key_ready", key_ready, 1'b1);

        // Round-robin fill with the output stalled
        ready_pct = 0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hF000_0000 + k;
            in_rot   = RW'(k);
            cycle();
            check("fill_accept", got_acc, 1'b1);
            check("fill_lane_dvalid", enc_dvalid_o[k], 1'b1);
            check("fill_lane_data", enc_data_o[k*W +: W], in_data);
        end
        in_data = 32'hF000_0004;
        in_rot  = 5'd4;
        check("fill_in_ready_low", in_ready, 1'b0);
        check("fill_in_flight", in_flight, N);
        t = 0;
        do begin
            cycle();
            t++;
        end while (!got_acc && t < 200);
        in_valid = 1'b0;
        check("fill_fifth_accept", got_acc, 1'b1);
        ready_pct = 50;
        drain();

        // Single word, known answer
        ready_pct = 100;
        out_ready = 1'b1;
        send(32'h12345678, 5'd4);
        drain();
        check("single_out", last_out, 32'h4864A682);

        // Ordering under random backpressure
        ready_pct = 50;
        base = $urandom;
        for (int i = 0; i < 64; i++) send(base + W'(i), RW'(i % 32));
        drain();

        // Rekey with three words outstanding
        ready_pct = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, RW'($urandom_range(0, 31)));
        model_key = 32'h0000FFFF;
        key_in    = model_key;
        key_load  = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
        in_rot    = RW'($urandom_range(0, 31));
        cycle();
        key_load = 1'b0;
        check("rekey_taken", key_ready, 1'b0);
        ready_pct = 50;
        viol = 0;
        t = 0;
        while (!key_ready && t < 300) begin
            if (in_ready) viol++;
            cycle();
            t++;
        end
        check("rekey_in_ready_low", viol, 0);
        check("rekey_done", key_ready, 1'b1);
        send(in_data, in_rot);
        for (int i = 0; i < 8; i++) send($urandom, RW'($urandom_range(0, 31)));
        drain();

        // Asynchronous reset with words outstanding
        ready_pct = 0;
        out_ready = 1'b0;
        send($urandom, RW'($urandom_range(0, 31)));
        send($urandom, RW'($urandom_range(0, 31)));
        cycle();
        #3;
        reset = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_in_flight", in_flight, 0);
        check("areset_enc_reset", enc_reset_o, 1'b1);
        check("areset_in_ready", in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_pct = 100;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
        acc0 = n_acc;
        out0 = n_out;
        repeat (20) cycle();
        in_valid = 1'b0;
        check("post_reset_no_accept", n_acc - acc0, 0);
        check("post_reset_no_out", n_out - out0, 0);

        model_key = $urandom;
        key_in    = model_key;
        key_load  = 1'b1;
        cycle();
        key_load = 1'b0;
        t = 0;
        while (!key_ready && t < 50) begin
            cycle();
            t++;
        end
        check("rekey_after_reset", key_ready, 1'b1);
        ready_pct = 50;
        for (int i = 0; i < 16; i++) send($urandom, RW'($urandom_range(0, 31)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
